stream_output_buffer: RTL
=========================

# stream_output_buffer

Elastic FIFO stage directly downstream of the leaf interface wrapper's user output port (`Output_1_V_V` / `_ap_vld` / `_ap_ack`). It accepts payload words with the vld/ack handshake, buffers up to 2^DEPTH_BITS words, and presents them to the downstream user operator with the same handshake. It decouples user-operator stalls from the leaf interface so the interface drains the BFT at full rate during short back-pressure bursts.

## Interface
- PAYLOAD_BITS, 32, width of one payload word; matches the leaf interface payload.
- DEPTH_BITS, 4, log2 of buffer depth (depth 16); legal range 1..10.
- clk  input  1  single clock for the whole block.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- din  input  PAYLOAD_BITS  word from leaf interface (`Output_1_V_V`).
- din_vld  input  1  word on din is valid.
- din_ack  output  1  block accepts din this cycle.
- dout  output  PAYLOAD_BITS  head-of-buffer word to user operator.
- dout_vld  output  1  dout holds a valid word.
- dout_ack  input  1  user operator accepts dout this cycle.
- level  output  DEPTH_BITS+1  current occupancy, 0..2^DEPTH_BITS.
- word_count  output  32  total words delivered on dout (only with STREAM_OUTPUT_BUFFER_STATS_EN).

## Operation
- Transfer rule, both sides: a word moves on the rising edge of clk where vld=1 and ack=1 in the same cycle. Source holds vld and data stable until acked.
- Storage: 2^DEPTH_BITS-entry RAM; write and read pointers of DEPTH_BITS+1 bits. Index = low DEPTH_BITS bits; the MSB distinguishes full from empty.
- Empty: pointers equal. Full: low bits equal and MSBs differ.
- Pointers increment modulo 2^(DEPTH_BITS+1); wrap-around is silent and needs no special case.
- din_ack = !full, a function of registered state only. No combinational path from din_vld or dout_ack.
- dout_vld = !empty; dout = RAM[read index], first-word-fall-through.
- Simultaneous push and pop on a non-empty, non-full buffer: both occur and level is unchanged.
- Push while full is impossible (ack low); a source holding vld waits. Pop while empty is impossible (vld low).
- Full plus dout_ack on the same edge: pop only. din_ack rises in the next cycle.
- Empty plus din push on the same edge: push only. dout_vld rises in the next cycle.
- level = write pointer minus read pointer, (DEPTH_BITS+1)-bit modular subtraction.
- Reset while a transfer is in progress: all contents are discarded, pointers go to 0, and any held din word must be resent by the source. RAM contents are not cleared.

## Timing
- Reset values: din_ack=1, dout_vld=0, level=0, word_count=0. dout is don't-care while dout_vld=0.
- Latency: a word accepted at edge N is on dout with dout_vld=1 in the cycle after edge N, so it can be popped at the earliest on edge N+1.
- Throughput: 1 word/cycle sustained on both sides simultaneously.
- Reset assertion clears state immediately (asynchronous). Deassertion is sampled by clk. The first push is possible on the first edge after deassertion.
- din_ack falls in the cycle after the edge that makes the buffer full.

## Configuration
- STREAM_OUTPUT_BUFFER_STATS_EN defined:
  - The word_count port and counter are present.
  - word_count increments by 1 on every dout transfer.
  - It wraps from 0xFFFFFFFF to 0 and resets to 0.
- STREAM_OUTPUT_BUFFER_STATS_EN undefined: the word_count port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then single word: push 0xDEADBEEF at edge 1 with dout_ack=0 -> dout_vld=1 and dout=0xDEADBEEF from cycle 2, level=1; ack at edge 3 -> level=0, dout_vld=0.
- Fill with dout_ack=0: push 0..15 (DEPTH_BITS=4) -> din_ack=0 after the 16th push, level=16; a 17th din_vld held high is not accepted.
- Drain from full: raise dout_ack -> outputs 0..15 in order on 16 consecutive edges, din_ack=1 after the first pop, final level=0.
- Streaming wrap: 100 words with din_vld and dout_ack held high -> all 100 delivered in order at 1/cycle, level stays 1, pointers wrap without loss.
- Full with simultaneous events: at level=16, assert din_vld and dout_ack together -> only the pop occurs, level=15; the push lands on the next edge, level returns to 16.
- Async reset mid-stream: drop reset at level=7 between edges -> dout_vld=0, din_ack=1, level=0 immediately; word_count=0 when STREAM_OUTPUT_BUFFER_STATS_EN is defined.

Source files
------------

// File: rtl/stream_output_buffer.sv
// Elastic first-word-fall-through FIFO between the leaf interface output port and the user operator.
// Optional delivered-word counter on word_count is enabled by defining STREAM_OUTPUT_BUFFER_STATS_EN.
module stream_output_buffer #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_ack,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack,
  output logic [DEPTH_BITS:0]     level
`ifdef STREAM_OUTPUT_BUFFER_STATS_EN
  ,
  output logic [31:0]             word_count
`endif
);

  localparam int DEPTH = 2 ** DEPTH_BITS;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS:0]     wr_ptr;
  logic [DEPTH_BITS:0]     rd_ptr;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  // The extra pointer MSB tells a full buffer apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                 (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);

  assign din_ack  = !full;
  assign dout_vld = !empty;
  assign dout     = mem[rd_ptr[DEPTH_BITS-1:0]];
  assign level    = wr_ptr - rd_ptr;

  assign push = din_vld && !full;
  assign pop  = dout_ack && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_BITS-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef STREAM_OUTPUT_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 32'd1;
    end
  end
`endif

endmodule
